// File: rtl/load_writeback.sv
// Writeback stage: byte-serial load engine (LB/LH/LW/LBU/LHU) merged with a
// single-cycle ALU result path onto one registered register-file write port.
module load_writeback #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_funct3,
    input  logic [3:0]        ld_rd,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [3:0]        alu_rd,
    input  logic [XLEN-1:0]   alu_value,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [3:0]        write_register,
    output logic [XLEN-1:0]   write_value,
    output logic              wr_en,
    output logic              ld_err
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on the matching valid, and upstream holds
    // its request stable until the transfer.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base;
    logic [2:0]        funct3_q;
    logic [3:0]        rd_q;
    logic [1:0]        idx;
    logic [1:0]        last_idx;
    logic [3:0][7:0]   byte_buf;

    logic              accept;
    logic              req_legal;
    logic              req_misaligned;
    logic              last_byte;
    logic              load_done;
    logic              alu_fire;
    logic [3:0][7:0]   word;
    logic [XLEN-1:0]   load_value;

    assign accept         = (state == IDLE) && ld_valid;
    assign req_legal      = ld_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign req_misaligned = ((ld_funct3[1:0] == 2'b01) && ld_addr[0]) ||
                            ((ld_funct3[1:0] == 2'b10) && (ld_addr[1:0] != 2'b00));
    assign last_byte      = (idx == last_idx);
    assign load_done      = (state == FETCH) && mem_ack && last_byte;
    assign alu_fire       = alu_valid && alu_ready;

    assign ld_ready  = (state == IDLE);
    assign mem_req   = (state == FETCH);
    assign ld_err    = (state == ERR);
    assign alu_ready = ~load_done;
    assign mem_addr  = base + ADDR_W'(idx);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ld_valid) begin
                    state_next = (!req_legal || req_misaligned) ? ERR : FETCH;
                end
            end
            FETCH: begin
                if (load_done) begin
                    state_next = IDLE;
                end
            end
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The last byte is still on mem_rdata when the result is formed.
    always_comb begin
        word      = byte_buf;
        word[idx] = mem_rdata;
    end

    always_comb begin
        load_value = '0;
        case (funct3_q)
            3'b000:  load_value = {{(XLEN-8){word[0][7]}}, word[0]};
            3'b001:  load_value = {{(XLEN-16){word[1][7]}}, word[1], word[0]};
            3'b100:  load_value = {{(XLEN-8){1'b0}}, word[0]};
            3'b101:  load_value = {{(XLEN-16){1'b0}}, word[1], word[0]};
            default: load_value = XLEN'(word);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base     <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            idx      <= '0;
            last_idx <= '0;
            byte_buf <= '0;
        end else begin
            if (accept) begin
                base     <= ld_addr;
                funct3_q <= ld_funct3;
                rd_q     <= ld_rd;
                idx      <= '0;
                case (ld_funct3[1:0])
                    2'b00:   last_idx <= 2'd0;
                    2'b01:   last_idx <= 2'd1;
                    default: last_idx <= 2'd3;
                endcase
            end
            if ((state == FETCH) && mem_ack) begin
                byte_buf[idx] <= mem_rdata;
                idx           <= idx + 2'd1;
            end
        end
    end

    // Load completion wins the write port; a blocked ALU result waits a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en          <= 1'b0;
            write_register <= '0;
            write_value    <= '0;
        end else if (load_done) begin
            wr_en          <= (rd_q != 4'd0);
            write_register <= rd_q;
            write_value    <= load_value;
        end else if (alu_fire) begin
            wr_en          <= (alu_rd != 4'd0);
            write_register <= alu_rd;
            write_value    <= alu_value;
        end else begin
            wr_en <= 1'b0;
        end
    end

endmodule

// File: doc/load_writeback.md
# load_writeback

Writeback stage of the RV32E core, directly upstream of the register file. It accepts load requests (LB/LH/LW/LBU/LHU) and single-cycle ALU results. Loads are fetched byte-serially over an 8-bit memory handshake, assembled little-endian and sign/zero-extended. Both paths are merged into the one register-file write port: write_register, write_value and wr_en.

## Interface
- XLEN, 32: data width.
- ADDR_W, 24: byte-address width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_valid  in  1  load request valid.
- ld_ready  out  1  ready to accept a load; high only in IDLE.
- ld_addr  in  ADDR_W  load byte address.
- ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes are illegal.
- ld_rd  in  4  destination register.
- alu_valid  in  1  ALU result valid; upstream holds it until accepted.
- alu_ready  out  1  ALU result accepted when valid and ready are both high.
- alu_rd  in  4  ALU destination register.
- alu_value  in  XLEN  ALU result.
- mem_req  out  1  byte read request.
- mem_addr  out  ADDR_W  byte address of current request.
- mem_ack  in  1  read data valid this cycle; ignored while mem_req is 0.
- mem_rdata  in  8  read byte.
- write_register  out  4  register-file write index.
- write_value  out  XLEN  register-file write data.
- wr_en  out  1  register-file write strobe; one-cycle pulse.
- ld_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- States:
  - IDLE: ld_ready=1. On ld_valid, capture addr, funct3, rd and byte count (1/2/4), clear the byte index, then check the request.
  - Check result: misaligned (LH with addr[0]=1; LW with addr[1:0]≠0) or illegal funct3 goes to ERR; otherwise go to FETCH.
  - FETCH: mem_req=1 and mem_addr=base+idx (mod 2^ADDR_W). On mem_ack, store mem_rdata into byte lane idx and increment idx. On the last byte's ack, go to IDLE and launch the writeback.
  - ERR: ld_err=1 for one cycle, then IDLE. No memory access and no write.
- Extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW uses all 32 bits as assembled.
- Writeback register:
  - Outputs write_register, write_value and wr_en are registered.
  - Each cycle they load either the load result (on the last-byte ack) or the ALU result (on an alu_valid & alu_ready handshake); otherwise wr_en=0.
  - Load has priority: alu_ready = ~(state==FETCH & mem_ack & last byte).
  - alu_ready does not depend on alu_valid.
- rd==0 (either path): the access completes normally, but wr_en stays 0 for that result.
- Reset values:
  - state IDLE, ld_ready=1, alu_ready=1.
  - mem_req=0, mem_addr=0.
  - wr_en=0, write_register=0, write_value=0, ld_err=0.
  - Byte buffer and index are cleared.

## Timing
- Load accepted in cycle N; the first mem_req is in cycle N+1.
- mem_addr advances in the cycle after each ack.
- mem_req stays high between bytes, with no gap.
- wr_en is high in the cycle after the last ack. ld_ready is high in that same cycle, so back-to-back loads are allowed.
- LW with zero-wait acks: requests in N+1..N+4, wr_en in N+5.
- Error path: ld_err in N+1, ld_ready back at N+2.
- ALU path: accepted in cycle M, wr_en in M+1. Sustained one result per cycle when no load is completing.
- rst in any state, including mid-FETCH: next cycle is in reset state. Partial bytes are discarded, and no wr_en or ld_err is produced.
- ld_valid while not ready is ignored; the request must be held by upstream.

## Test plan
- Reset: pulse rst for 2 cycles. Next cycle: wr_en=0, mem_req=0, ld_err=0, ld_ready=1, alu_ready=1.
- LW, rd=5, addr 0x000104, bytes 0x78,0x56,0x34,0x12, ack every cycle: mem_addr 0x104..0x107 across 4 cycles, then a single wr_en with write_register=5 and write_value=0x12345678, 5 cycles after accept.
- Extension with waits (2 idle cycles before each ack): LB @0x000003 byte 0x80 writes 0xFFFFFF80. LBU of the same writes 0x00000080. LH @0x000010 bytes 0x34,0x85 writes 0xFFFF8534. LHU writes 0x00008534.
- Errors: LW @0x000102, LH @0x000011 and funct3=011 each give one ld_err pulse, mem_req never high and wr_en never high.
- Collision: hold alu_valid (rd=3, 0xDEADBEEF) during an LW (rd=7). alu_ready=0 in the last-ack cycle. Load write (rd=7) comes first; the ALU write (rd=3, 0xDEADBEEF) follows in the next cycle.
- rd=0 and mid-load reset: a load with rd=0 completes all memory requests with no wr_en. rst asserted after 2 of 4 LW bytes gives mem_req=0 next cycle, no wr_en, ld_ready=1.
